// File: rtl/row_select_seq_if.sv
// Row-access bus between the access controller (master) and the row sequencer (slave).
interface row_select_seq_if #(
  parameter int ADR_W = 3,
  parameter int ROWS  = 8
);
  logic             req;
  logic             we;
  logic [ADR_W-1:0] adr;
  logic             ready;
  logic [ROWS-1:0]  sel;
  logic             wr_en;
  logic             rd_en;
  logic             done;
  logic             err;

  modport master (
    output req, we, adr,
    input  ready, sel, wr_en, rd_en, done, err
  );

  modport slave (
    input  req, we, adr,
    output ready, sel, wr_en, rd_en, done, err
  );
endinterface

// File: rtl/row_select_seq.sv
// Sequenced row decoder: one access per handshake, one-hot sel for PULSE_CYC cycles,
// then GAP_CYC precharge cycles. All outputs registered.
//
// state  | meaning
// IDLE   | ready, waiting for req
// ACTIVE | sel/wr_en/rd_en driven for the latched row
// PRECHG | precharge gap, all selects low
// ERROR  | single-cycle err pulse for an out-of-range address
module row_select_seq #(
  parameter int ADR_W     = 3,
  parameter int ROWS      = 8,
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  row_select_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACTIVE, PRECHG, ERROR} state_t;

  localparam int CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [ADR_W:0]   ROWS_C   = (ADR_W + 1)'(ROWS);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ROWS-1:0]  sel_q, sel_d;
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    ready_d = ready_q;
    case (state_q)
      IDLE: begin
        if (bus.req && ready_q) begin
          ready_d = 1'b0;
          if ({1'b0, bus.adr} < ROWS_C) begin
            state_d = ACTIVE;
            cnt_d   = PULSE_LD;
            sel_d   = ROWS'(1) << bus.adr;
            wr_d    = bus.we;
            rd_d    = !bus.we;
            done_d  = (PULSE_CYC == 1);
          end else begin
            state_d = ERROR;
            cnt_d   = '0;
            err_d   = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (cnt_q == '0) begin
          sel_d = '0;
          wr_d  = 1'b0;
          rd_d  = 1'b0;
          if (GAP_CYC > 0) begin
            state_d = PRECHG;
            cnt_d   = GAP_LD;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          // done lands in the cycle where the counter will read zero
          done_d = (cnt_q == CNT_W'(1));
        end
      end
      PRECHG: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ERROR: begin
        state_d = IDLE;
        cnt_d   = '0;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        sel_d   = '0;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  assign bus.ready = ready_q;
  assign bus.sel   = sel_q;
  assign bus.wr_en = wr_q;
  assign bus.rd_en = rd_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_row_select_seq.sv
// Bench for row_select_seq: directed table on the default build, hand sequences for
// reset/ROWS=6/no-gap builds, and a randomized run checked against a schedule model.
module tb_row_select_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  row_select_seq_if #(.ADR_W(3), .ROWS(8)) if_a ();
  row_select_seq_if #(.ADR_W(3), .ROWS(6)) if_b ();
  row_select_seq_if #(.ADR_W(3), .ROWS(8)) if_c ();

  row_select_seq #(.ADR_W(3), .ROWS(8), .PULSE_CYC(2), .GAP_CYC(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  row_select_seq #(.ADR_W(3), .ROWS(6), .PULSE_CYC(2), .GAP_CYC(1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
  row_select_seq #(.ADR_W(3), .ROWS(8), .PULSE_CYC(1), .GAP_CYC(0))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

  typedef struct {
    logic       req;
    logic       we;
    logic [2:0] adr;
    logic       ready;
    logic [7:0] sel;
    logic       wr;
    logic       rd;
    logic       done;
    logic       err;
  } vec_t;

  vec_t tbl [13];

  localparam int NR  = 10000;
  localparam int P_B = 2;
  localparam int G_B = 1;
  localparam int R_B = 6;

  logic [5:0] esel  [0:NR+16];
  logic       ewr   [0:NR+16];
  logic       erd   [0:NR+16];
  logic       edone [0:NR+16];
  logic       eerr  [0:NR+16];

  function automatic logic [31:0] out_a();
    return {19'd0, if_a.ready, if_a.sel, if_a.wr_en, if_a.rd_en, if_a.done, if_a.err};
  endfunction

  function automatic logic [31:0] out_b();
    return {21'd0, if_b.ready, if_b.sel, if_b.wr_en, if_b.rd_en, if_b.done, if_b.err};
  endfunction

  function automatic logic [31:0] out_c();
    return {19'd0, if_c.ready, if_c.sel, if_c.wr_en, if_c.rd_en, if_c.done, if_c.err};
  endfunction

  // expected words below are {ready, sel, wr_en, rd_en, done, err}
  function automatic logic [31:0] w8(logic rdy, logic [7:0] s, logic w, logic r, logic d, logic e);
    return {19'd0, rdy, s, w, r, d, e};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rdy_from;
    int last_acc;
    int n_valid;
    int n_done;
    logic r_req, r_we, dut_acc;
    logic [2:0] r_adr;

    {if_a.req, if_a.we, if_a.adr} = '0;
    {if_b.req, if_b.we, if_b.adr} = '0;
    {if_c.req, if_c.we, if_c.adr} = '0;

    tbl[0]  = '{1'b0, 1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 3'd5, 1'b0, 8'h20, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 3'd5, 1'b0, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 3'd5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 3'd5, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 3'd0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 3'd7, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 3'd7, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 3'd7, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 3'd7, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 3'd7, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 3'd7, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_a", out_a(), w8(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    chk("reset_b", out_b(), {21'd0, 1'b1, 6'h00, 4'b0000});
    rst_n = 1'b1;

    // directed table on the default build: single read, then back-to-back writes
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if_a.req = tbl[i].req;
      if_a.we  = tbl[i].we;
      if_a.adr = tbl[i].adr;
      step();
      chk($sformatf("table_a[%0d]", i), out_a(),
          w8(tbl[i].ready, tbl[i].sel, tbl[i].wr, tbl[i].rd, tbl[i].done, tbl[i].err));
    end

    // reset in the first ACTIVE cycle
    @(negedge clk);
    if_a.req = 1'b1; if_a.we = 1'b0; if_a.adr = 3'd2;
    step();
    chk("rst_pre_sel", out_a(), w8(1'b0, 8'h04, 1'b0, 1'b1, 1'b0, 1'b0));
    if_a.req = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("rst_async", out_a(), w8(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    step();
    chk("rst_no_done", out_a(), w8(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    if_a.req = 1'b1; if_a.we = 1'b1; if_a.adr = 3'd1;
    step();
    chk("post_rst_acc", out_a(), w8(1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    if_a.req = 1'b0;
    step();
    chk("post_rst_done", out_a(), w8(1'b0, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0));
    step();
    chk("post_rst_gap", out_a(), w8(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    step();
    chk("post_rst_ready", out_a(), w8(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));

    // no-gap single-cycle build with req held high
    @(negedge clk);
    if_c.req = 1'b1; if_c.we = 1'b0; if_c.adr = 3'd3;
    step();
    chk("c_acc0", out_c(), w8(1'b0, 8'h08, 1'b0, 1'b1, 1'b1, 1'b0));
    @(negedge clk);
    if_c.we = 1'b1; if_c.adr = 3'd4;
    step();
    chk("c_idle", out_c(), w8(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    step();
    chk("c_acc1", out_c(), w8(1'b0, 8'h10, 1'b1, 1'b0, 1'b1, 1'b0));
    @(negedge clk);
    if_c.req = 1'b0;
    step();
    chk("c_end", out_c(), w8(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));

    // ROWS=6 build: out-of-range address
    @(negedge clk);
    if_b.req = 1'b1; if_b.we = 1'b0; if_b.adr = 3'd6;
    step();
    chk("b_err", out_b(), {21'd0, 1'b1 & 1'b0, 6'h00, 4'b0001});
    @(negedge clk);
    if_b.req = 1'b0;
    step();
    chk("b_err_ready", out_b(), {21'd0, 1'b1, 6'h00, 4'b0000});
    @(negedge clk);
    if_b.req = 1'b1; if_b.we = 1'b1; if_b.adr = 3'd5;
    step();
    chk("b_row5", out_b(), {21'd0, 1'b0, 6'h20, 4'b1000});
    @(negedge clk);
    if_b.req = 1'b0;
    repeat (3) step();

    // randomized run on the ROWS=6 build against a cycle schedule model
    for (int i = 0; i <= NR + 16; i++) begin
      esel[i] = '0; ewr[i] = 1'b0; erd[i] = 1'b0; edone[i] = 1'b0; eerr[i] = 1'b0;
    end
    rdy_from = -1;
    last_acc = -1;
    n_valid  = 0;
    n_done   = 0;
    for (int e = 0; e < NR + 6; e++) begin
      @(negedge clk);
      r_req = (e < NR) ? ($urandom_range(0, 3) != 0) : 1'b0;
      r_we  = 1'($urandom);
      r_adr = 3'($urandom_range(0, 7));
      if_b.req = r_req; if_b.we = r_we; if_b.adr = r_adr;
      dut_acc = if_b.req & if_b.ready;
      if (r_req && e > rdy_from) begin
        if (int'(r_adr) < R_B) begin
          for (int k = 0; k < P_B; k++) begin
            esel[e+k] = 6'(1) << r_adr;
            ewr[e+k]  = r_we;
            erd[e+k]  = !r_we;
          end
          edone[e+P_B-1] = 1'b1;
          rdy_from = e + P_B + G_B;
          n_valid++;
        end else begin
          eerr[e]  = 1'b1;
          rdy_from = e + 1;
        end
      end
      if (dut_acc) begin
        if (last_acc >= 0) begin
          checks++;
          if (e - last_acc < 1 + P_B + G_B) begin
            errors++;
            $display("FAIL spacing: got %0d cycles required >= %0d", e - last_acc, 1 + P_B + G_B);
          end
        end
        last_acc = (int'(r_adr) < R_B) ? e : -1;
      end
      step();
      chk($sformatf("rand_b[%0d]", e), out_b(),
          {21'd0, (e >= rdy_from), esel[e], ewr[e], erd[e], edone[e], eerr[e]});
      checks++;
      if (!$onehot0(if_b.sel) || (if_b.wr_en && if_b.rd_en) ||
          ((if_b.sel != '0) != (if_b.wr_en || if_b.rd_en)) || (if_b.done && if_b.err)) begin
        errors++;
        $display("FAIL invariant[%0d]: got sel=%h wr=%b rd=%b done=%b err=%b required legal combination",
                 e, if_b.sel, if_b.wr_en, if_b.rd_en, if_b.done, if_b.err);
      end
      if (if_b.done) n_done++;
    end
    chk("done_count", 32'(n_done), 32'(n_valid));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
